// File: rtl/mac_seq_pkg.sv
// Shared types and sizing helpers for the MAC stream sequencer.
package mac_seq_pkg;

  // Sequencer phases: coefficient load, streaming, and quiesce before reload.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TAPS       = 9;

  // Bits needed to index 0..n-1; never less than one bit.
  function automatic int tap_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_result_slot.sv
// Single-entry valid/ready output register. A capture always lands, even when
// the current entry pops in the same cycle; the sequencer's back-pressure rule
// guarantees the slot is never holding an unpopped result at capture time.
module mac_result_slot
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  pop_ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  // Capture wins over pop so a result arriving as the old one leaves keeps valid high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= cap_data;
    end else if (pop_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_stream_sequencer.sv
// Control-and-feed front end for the external 8-bit MAC: holds the coefficient
// bank and bias, steps a tap counter over the sample stream, drives the MAC
// operand/enable lines and captures one result per TAPS-sample window.
module mac_stream_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAPS       = DEF_TAPS
) (
  input  logic                  clk,
  input  logic                  reset,
  // coefficient stream: TAPS coefficients (tap 0 first) then bias
  input  logic                  k_TVALID,
  output logic                  k_TREADY,
  input  logic [DATA_WIDTH-1:0] k_TDATA,
  input  logic                  cfg_reload,
  // sample stream
  input  logic                  s_TVALID,
  output logic                  s_TREADY,
  input  logic [DATA_WIDTH-1:0] s_TDATA,
  // result stream
  output logic                  m_TVALID,
  input  logic                  m_TREADY,
  output logic [DATA_WIDTH-1:0] m_TDATA,
  // MAC side
  output logic [DATA_WIDTH-1:0] mac_i_TDATA,
  output logic [DATA_WIDTH-1:0] mac_k_TDATA,
  output logic [DATA_WIDTH-1:0] mac_b_TDATA,
  output logic                  mac_r_enable,
  output logic                  mac_a_enable,
  output logic                  mac_b_enable,
  input  logic [DATA_WIDTH-1:0] mac_o_TDATA
);

  localparam int TW         = tap_w(TAPS);
  localparam int IW         = tap_w(TAPS + 1);
  localparam int CAP_STAGES = 1;
  localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);
  localparam logic [IW-1:0] BIAS_IDX = IW'(TAPS);

  if (TAPS < 3 || TAPS > 256) begin : g_taps_chk
    $error("mac_stream_sequencer: TAPS=%0d outside 3..256", TAPS);
  end

  seq_state_e              state, state_nxt;
  logic [TW-1:0]           tap;
  logic [IW-1:0]           ld_idx;
  logic [DATA_WIDTH-1:0]   coef [TAPS];
  logic [DATA_WIDTH-1:0]   bias;
  logic                    reload_pend;
  logic                    k_fire, s_fire;
  logic                    last_fire;
  logic [CAP_STAGES:0]     vld_pipe;
  logic                    capture;

  assign k_fire    = k_TVALID && k_TREADY;
  assign s_fire    = s_TVALID && s_TREADY;
  assign last_fire = s_fire && (tap == LAST_TAP);

  // Next-state and handshake decode. The last tap is held off while an
  // unpopped result sits in the slot, so the capture two cycles later always
  // finds it free. A pending reload only takes effect on a window boundary.
  always_comb begin
    state_nxt = state;
    k_TREADY  = 1'b0;
    s_TREADY  = 1'b0;
    unique case (state)
      LOAD: begin
        k_TREADY = 1'b1;
        if (k_TVALID && ld_idx == BIAS_IDX) state_nxt = RUN;
      end
      RUN: begin
        if (reload_pend && tap == '0) state_nxt = DRAIN;
        else s_TREADY = !((tap == LAST_TAP) && m_TVALID && !m_TREADY);
      end
      DRAIN: begin
        if (!mac_a_enable && vld_pipe == '0) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  // Coefficient bank and bias load; ld_idx walks 0..TAPS, TAPS being the bias slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
      bias   <= '0;
      ld_idx <= '0;
    end else if (k_fire) begin
      if (ld_idx == BIAS_IDX) begin
        bias   <= k_TDATA;
        ld_idx <= '0;
      end else begin
        for (int i = 0; i < TAPS; i++)
          if (ld_idx == IW'(i)) coef[i] <= k_TDATA;
        ld_idx <= ld_idx + IW'(1);
      end
    end
  end

  // Tap counter advances per accepted sample and wraps after the last tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      tap <= '0;
    else if (s_fire) tap <= (tap == LAST_TAP) ? '0 : tap + TW'(1);
  end

  // Reload request is remembered until the sequencer leaves RUN for DRAIN.
  // Requests outside RUN are dropped: the block is already loading or draining.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     reload_pend <= 1'b0;
    else if (state == RUN && state_nxt == DRAIN)    reload_pend <= 1'b0;
    else if (cfg_reload && state == RUN)            reload_pend <= 1'b1;
  end

  // MAC enables trail the product load by one cycle; vld_pipe tracks the
  // window's last sample through accumulate to the capture cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_a_enable <= 1'b0;
      mac_b_enable <= 1'b0;
      vld_pipe     <= '0;
    end else begin
      mac_a_enable <= s_fire;
      mac_b_enable <= s_fire && (tap == '0);
      vld_pipe     <= {vld_pipe[CAP_STAGES-1:0], last_fire};
    end
  end

  assign capture      = vld_pipe[CAP_STAGES];
  assign mac_i_TDATA  = s_TDATA;
  assign mac_k_TDATA  = coef[tap];
  assign mac_b_TDATA  = bias;
  assign mac_r_enable = s_fire;

  mac_result_slot #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .cap_data  (mac_o_TDATA),
    .pop_ready (m_TREADY),
    .valid     (m_TVALID),
    .data      (m_TDATA)
  );

endmodule

// File: tb/tb_mac_stream_sequencer.sv
// Bench for mac_stream_sequencer with a behavioural MAC beside it and a
// sum-of-products reference model feeding a result scoreboard.
module tb_mac_stream_sequencer;

  localparam int DW   = 8;
  localparam int TAPS = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          k_TVALID = 1'b0;
  logic          k_TREADY;
  logic [DW-1:0] k_TDATA = '0;
  logic          cfg_reload = 1'b0;
  logic          s_TVALID = 1'b0;
  logic          s_TREADY;
  logic [DW-1:0] s_TDATA = '0;
  logic          m_TVALID;
  logic          m_TREADY = 1'b0;
  logic [DW-1:0] m_TDATA;
  logic [DW-1:0] mac_i_TDATA, mac_k_TDATA, mac_b_TDATA, mac_o_TDATA;
  logic          mac_r_enable, mac_a_enable, mac_b_enable;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int rdy_mode = 0;

  mac_stream_sequencer #(.DATA_WIDTH(DW), .TAPS(TAPS)) dut (
    .clk(clk), .reset(reset),
    .k_TVALID(k_TVALID), .k_TREADY(k_TREADY), .k_TDATA(k_TDATA),
    .cfg_reload(cfg_reload),
    .s_TVALID(s_TVALID), .s_TREADY(s_TREADY), .s_TDATA(s_TDATA),
    .m_TVALID(m_TVALID), .m_TREADY(m_TREADY), .m_TDATA(m_TDATA),
    .mac_i_TDATA(mac_i_TDATA), .mac_k_TDATA(mac_k_TDATA), .mac_b_TDATA(mac_b_TDATA),
    .mac_r_enable(mac_r_enable), .mac_a_enable(mac_a_enable), .mac_b_enable(mac_b_enable),
    .mac_o_TDATA(mac_o_TDATA)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External MAC: product register, then accumulate (bias-seeded on b_enable).
  logic [DW-1:0] mac_prod, mac_acc;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_prod <= '0;
      mac_acc  <= '0;
    end else begin
      if (mac_r_enable) mac_prod <= DW'(mac_i_TDATA * mac_k_TDATA);
      if (mac_a_enable) mac_acc  <= (mac_b_enable ? mac_b_TDATA : mac_acc) + mac_prod;
    end
  end
  assign mac_o_TDATA = mac_acc;

  // Random output back-pressure when enabled.
  always @(posedge clk) begin
    if (rdy_mode != 0) begin
      #1 m_TREADY = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model + scoreboard, sampled mid-cycle on accepted handshakes.
  int mdl_coef [TAPS];
  int mdl_bias = 0;
  int mdl_ld = 0;
  int win[$];
  int exp_q[$];
  int last_cyc = 0;

  always @(negedge clk) begin : monitor
    int sum;
    if (!reset) begin
      win.delete();
      exp_q.delete();
      mdl_ld = 0;
    end else begin
      if (k_TVALID && k_TREADY) begin
        if (mdl_ld < TAPS) mdl_coef[mdl_ld] = int'(k_TDATA);
        else               mdl_bias = int'(k_TDATA);
        mdl_ld = (mdl_ld == TAPS) ? 0 : mdl_ld + 1;
      end
      if (s_TVALID && s_TREADY) begin
        win.push_back(int'(s_TDATA));
        last_cyc = cyc;
        if (win.size() == TAPS) begin
          sum = mdl_bias;
          for (int j = 0; j < TAPS; j++) sum += win[j] * mdl_coef[j];
          exp_q.push_back(sum % 256);
          win.delete();
        end
      end
      if (m_TVALID && m_TREADY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_extra: got %0d expected no result", m_TDATA);
        end else begin
          check("result", m_TDATA, exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_k(input logic [DW-1:0] d);
    int t = 0;
    k_TVALID = 1'b1;
    k_TDATA  = d;
    @(negedge clk);
    while (!k_TREADY && t < 200) begin t++; @(negedge clk); end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL k_handshake_timeout: got no k_TREADY expected within 200 cycles");
    end
    @(posedge clk); #1;
    k_TVALID = 1'b0;
  endtask

  task automatic send_s(input logic [DW-1:0] d);
    int t = 0;
    s_TVALID = 1'b1;
    s_TDATA  = d;
    @(negedge clk);
    while (!s_TREADY && t < 200) begin t++; @(negedge clk); end
    stall_cnt += t;
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL s_handshake_timeout: got no s_TREADY expected within 200 cycles");
    end
    @(posedge clk); #1;
    s_TVALID = 1'b0;
  endtask

  task automatic load(input logic [DW-1:0] c0, c1, c2, b);
    send_k(c0); send_k(c1); send_k(c2); send_k(b);
  endtask

  task automatic window(input logic [DW-1:0] a0, a1, a2);
    send_s(a0); send_s(a1); send_s(a2);
  endtask

  task automatic reload();
    cfg_reload = 1'b1;
    @(posedge clk); #1;
    cfg_reload = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
    check(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_k_TREADY"}, k_TREADY, 1);
    check({tag, "_s_TREADY"}, s_TREADY, 0);
    check({tag, "_m_TVALID"}, m_TVALID, 0);
    check({tag, "_m_TDATA"}, m_TDATA, 0);
    check({tag, "_a_enable"}, mac_a_enable, 0);
    check({tag, "_b_enable"}, mac_b_enable, 0);
    check({tag, "_r_enable"}, mac_r_enable, 0);
    check({tag, "_coef0"}, mac_k_TDATA, 0);
    check({tag, "_bias"}, mac_b_TDATA, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected end within 500000 time units");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    // reset values while held in reset
    s_TVALID = 1'b1;
    s_TDATA  = 8'd9;
    #12;
    check_reset_outputs("rst");
    s_TVALID = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);

    // basic window with latency measurement
    m_TREADY = 1'b1;
    load(8'd1, 8'd2, 8'd3, 8'd4);
    check("k_ready_after_load", k_TREADY, 0);
    window(8'd5, 8'd6, 8'd7);
    t = 0;
    @(negedge clk);
    while (!m_TVALID && t < 20) begin t++; @(negedge clk); end
    check("latency", cyc - last_cyc, 3);
    @(posedge clk); #1;
    wait_empty("basic_drain");

    // back-to-back windows, no stalls expected
    stall_cnt = 0;
    window(8'd5, 8'd6, 8'd7);
    window(8'd1, 8'd1, 8'd1);
    check("b2b_stalls", stall_cnt, 0);
    wait_empty("b2b_drain");

    // output stall holds off the second window's last tap
    m_TREADY = 1'b0;
    window(8'd5, 8'd6, 8'd7);
    send_s(8'd1);
    send_s(8'd1);
    s_TVALID = 1'b1;
    s_TDATA  = 8'd1;
    repeat (3) @(negedge clk);
    check("stall_last_tap_ready", s_TREADY, 0);
    check("stall_result_held", m_TVALID, 1);
    @(posedge clk); #1;
    m_TREADY = 1'b1;
    send_s(8'd1);
    wait_empty("stall_drain");

    // reload mid-window: old coefs finish, k_TREADY only after capture
    send_s(8'd5);
    reload();
    send_s(8'd6);
    send_s(8'd7);
    t = 0;
    @(negedge clk);
    while (!k_TREADY && t < 20) begin t++; @(negedge clk); end
    check("reload_after_capture", exp_q.size(), 0);
    @(posedge clk); #1;
    load(8'd0, 8'd0, 8'd1, 8'd0);
    window(8'd5, 8'd6, 8'd7);
    wait_empty("reload_drain");

    // modulo wrap
    reload();
    load(8'd100, 8'd100, 8'd100, 8'd0);
    window(8'd1, 8'd1, 8'd1);
    wait_empty("wrap_drain");

    // randomized coefficients, samples, gaps and back-pressure
    reload();
    load(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    rdy_mode = 1;
    for (int w = 0; w < 6; w++) begin
      for (int j = 0; j < TAPS; j++) begin
        idle(int'($urandom_range(0, 2)));
        send_s(8'($urandom));
      end
    end
    rdy_mode = 0;
    idle(1);
    m_TREADY = 1'b1;
    wait_empty("random_drain");

    // reset in the middle of a window
    reload();
    load(8'd1, 8'd2, 8'd3, 8'd4);
    send_s(8'd5);
    s_TVALID = 1'b1;
    s_TDATA  = 8'd6;
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    s_TVALID = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);
    check("post_reset_load", k_TREADY, 1);
    load(8'd2, 8'd0, 8'd1, 8'd9);
    window(8'd5, 8'd6, 8'd7);
    wait_empty("post_reset_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
